// File: rtl/sm3_cf_arbiter_pkg.sv
// Shared constants and FSM state type for the SM3 compression-core arbiter.
package sm3_pkg;

  localparam logic [255:0] SM3_IV =
    256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;

  localparam int V_W   = 256;
  localparam int BLK_W = 512;
  localparam int NREQ  = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/sm3_cf_arbiter_if.sv
// Requester and compression-core signals of the arbiter, grouped in one bundle.
interface sm3_cf_arbiter_if;
  import sm3_pkg::*;

  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_first;
  logic [BLK_W-1:0] req_block0;
  logic [BLK_W-1:0] req_block1;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  resp_valid;
  logic [V_W-1:0]   resp_v;
  logic             cf_enable;
  logic [V_W-1:0]   cf_inputV;
  logic [BLK_W-1:0] cf_messageBlock;
  logic [V_W-1:0]   cf_outputV;
  logic             cf_finished;

  modport slave (
    input  req_valid, req_first, req_block0, req_block1, cf_outputV, cf_finished,
    output req_ready, resp_valid, resp_v, cf_enable, cf_inputV, cf_messageBlock
  );

  modport master (
    output req_valid, req_first, req_block0, req_block1, cf_outputV, cf_finished,
    input  req_ready, resp_valid, resp_v, cf_enable, cf_inputV, cf_messageBlock
  );

endinterface

// File: rtl/sm3_cf_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone valid wins; on a tie the pointer decides.
module sm3_rr_pick
  import sm3_pkg::*;
(
  input  logic [NREQ-1:0] i_valid,
  input  logic            i_ptr,
  output logic [NREQ-1:0] o_grant
);

  always_comb begin
    o_grant = i_valid;
    if (&i_valid) o_grant = i_ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/sm3_cf_arbiter.sv
// Arbitrates two message streams onto one SM3 compression core, keeping a
// chaining value per requester and aborting hung core runs with a watchdog.
module sm3_cf_arbiter #(
  parameter logic [255:0] SM3_IV      = sm3_pkg::SM3_IV,
  parameter int unsigned  WDOG_CYCLES = 1023
) (
  input  logic            clk,
  input  logic            rst,
  sm3_cf_arbiter_if.slave bus,
  output logic            wdog_err
);

  localparam int unsigned   CW       = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);
  localparam logic [CW-1:0] WDOG_MAX = CW'(WDOG_CYCLES);

  sm3_pkg::state_e          r_state;
  sm3_pkg::state_e          w_next;
  logic [sm3_pkg::NREQ-1:0] w_grant;
  logic                     w_gidx;
  logic                     w_timeout;
  logic                     r_idx;
  logic                     r_ptr;
  logic [CW-1:0]            r_wdog;
  logic [sm3_pkg::V_W-1:0]  r_chain [sm3_pkg::NREQ];

  sm3_rr_pick u_pick (
    .i_valid (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  assign w_gidx    = w_grant[1];
  assign w_timeout = (r_wdog == WDOG_MAX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= sm3_pkg::S_IDLE;
    else     r_state <= w_next;
  end

  // RELEASE always falls through to IDLE so the core sees cf_enable low for a cycle.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = '0;
    bus.cf_enable = 1'b0;
    case (r_state)
      sm3_pkg::S_IDLE: begin
        bus.req_ready = rst ? '0 : w_grant;
        if (|w_grant) w_next = sm3_pkg::S_BUSY;
      end
      sm3_pkg::S_BUSY: begin
        bus.cf_enable = 1'b1;
        if (bus.cf_finished || w_timeout) w_next = sm3_pkg::S_RELEASE;
      end
      sm3_pkg::S_RELEASE: w_next = sm3_pkg::S_IDLE;
      default:            w_next = sm3_pkg::S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr               <= 1'b0;
      r_idx               <= 1'b0;
      r_wdog              <= '0;
      wdog_err            <= 1'b0;
      r_chain[0]          <= SM3_IV;
      r_chain[1]          <= SM3_IV;
      bus.cf_inputV       <= '0;
      bus.cf_messageBlock <= '0;
      bus.resp_v          <= '0;
      bus.resp_valid      <= '0;
    end else begin
      bus.resp_valid <= '0;
      case (r_state)
        sm3_pkg::S_IDLE: begin
          if (|w_grant) begin
            bus.cf_messageBlock <= w_gidx ? bus.req_block1 : bus.req_block0;
            bus.cf_inputV       <= bus.req_first[w_gidx] ? SM3_IV : r_chain[w_gidx];
            r_idx               <= w_gidx;
            r_ptr               <= ~w_gidx;
            r_wdog              <= '0;
          end
        end
        sm3_pkg::S_BUSY: begin
          if (bus.cf_finished) begin
            r_chain[r_idx] <= bus.cf_outputV;
            bus.resp_v     <= bus.cf_outputV;
            bus.resp_valid <= {r_idx, ~r_idx};
          end else if (w_timeout) begin
            wdog_err <= 1'b1;
          end else begin
            r_wdog <= r_wdog + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_cf_arbiter.sv
// Bench for sm3_cf_arbiter: behavioural SM3 core, scoreboard of expected responses.
module tb_sm3_cf_arbiter;

  localparam int WDOG = 40;
  localparam logic [255:0] IV =
    256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [255:0] ABC_DIGEST =
    256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [255:0] ABCD_DIGEST =
    256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

  typedef struct {
    logic         idx;
    logic [255:0] v;
  } exp_t;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] first;
    logic [1:0] grant;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic wdog_err;

  sm3_cf_arbiter_if bus ();

  sm3_cf_arbiter #(.WDOG_CYCLES(WDOG)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .wdog_err (wdog_err)
  );

  always #5 clk = ~clk;

  int           n_chk = 0;
  int           n_pass = 0;
  exp_t         exp_q[$];
  logic [255:0] mchain [2];
  logic [511:0] blk_be [2];
  int           core_lat = 0;
  bit           core_hang = 1'b0;
  int           fin_req = 0;
  int           fin_ack = 0;
  int           core_wait = 0;

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    int k;
    k = n % 32;
    return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rol(x, 9) ^ rol(x, 17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  // Message blocks are kept big-endian here; on the bus message bit 0 sits at block bit 0.
  function automatic logic [511:0] rev512(input logic [511:0] x);
    logic [511:0] r;
    for (int i = 0; i < 512; i++) r[511 - i] = x[i];
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w [68];
    logic [31:0] wp [64];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, tj, ff, gg;
    for (int j = 0; j < 16; j++) w[j] = b[511 - 32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rol(w[j-3], 15)) ^ rol(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      tj  = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rol(rol(a, 12) + e + rol(tj, j), 7);
      ss2 = ss1 ^ rol(a, 12);
      ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + wp[j];
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rol(bb, 9); bb = a; a = tt1;
      h = g; g = rol(f, 19); f = e; e = p0(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  // Core model: finishes core_lat cycles after seeing cf_enable, or never when hung.
  initial begin
    bus.cf_finished = 1'b0;
    bus.cf_outputV  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.cf_finished = 1'b0;
      if (fin_req != fin_ack) begin
        fin_ack         = fin_req;
        bus.cf_outputV  = {8{32'hdeadbeef}};
        bus.cf_finished = 1'b1;
      end else if (bus.cf_enable && !core_hang) begin
        if (core_wait >= core_lat) begin
          bus.cf_outputV  = sm3_cf(bus.cf_inputV, rev512(bus.cf_messageBlock));
          bus.cf_finished = 1'b1;
          core_wait       = 0;
        end else begin
          core_wait++;
        end
      end else begin
        core_wait = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (bus.resp_valid !== 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 256'(bus.resp_valid), 256'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_valid", 256'(bus.resp_valid), 256'({e.idx, ~e.idx}));
        chk("resp_v", bus.resp_v, e.v);
      end
    end
  endtask

  task automatic issue(input logic [1:0] valid, input logic [1:0] first,
                       input logic [1:0] exp_g, input bit track, input string nm);
    int           n;
    logic         idx;
    logic [255:0] v;
    exp_t         e;
    bus.req_block0 = rev512(blk_be[0]);
    bus.req_block1 = rev512(blk_be[1]);
    bus.req_valid  = valid;
    bus.req_first  = first;
    #1;
    n = 0;
    while (bus.req_ready == 2'b00 && n < 10) begin
      cycle();
      #1;
      n++;
    end
    chk({"grant_", nm}, 256'(bus.req_ready), 256'(exp_g));
    if (bus.req_ready == 2'b00) begin
      bus.req_valid = 2'b00;
      return;
    end
    idx = bus.req_ready[1];
    v   = first[idx] ? IV : mchain[idx];
    if (track) begin
      e.idx       = idx;
      e.v         = sm3_cf(v, blk_be[idx]);
      mchain[idx] = e.v;
      exp_q.push_back(e);
    end
    cycle();
    bus.req_valid  = 2'b00;
    bus.req_block0 = rand512();
    bus.req_block1 = rand512();
    #1;
    chk({"busy_en_", nm}, 256'(bus.cf_enable), 256'd1);
    chk({"busy_iv_", nm}, bus.cf_inputV, v);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    chk({"drain_", nm}, 256'(exp_q.size()), 256'd0);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    cycle();
    cycle();
    rst       = 1'b0;
    mchain[0] = IV;
    mchain[1] = IV;
    exp_q.delete();
  endtask

  initial begin
    vec_t         tbl [10];
    logic [511:0] abc_blk, abcd1_blk, abcd2_blk;
    int           n;

    tbl[0] = '{2'b11, 2'b11, 2'b01};
    tbl[1] = '{2'b11, 2'b00, 2'b10};
    tbl[2] = '{2'b11, 2'b00, 2'b01};
    tbl[3] = '{2'b11, 2'b00, 2'b10};
    tbl[4] = '{2'b01, 2'b00, 2'b01};
    tbl[5] = '{2'b01, 2'b00, 2'b01};
    tbl[6] = '{2'b11, 2'b00, 2'b10};
    tbl[7] = '{2'b10, 2'b00, 2'b10};
    tbl[8] = '{2'b11, 2'b10, 2'b01};
    tbl[9] = '{2'b10, 2'b10, 2'b10};

    abc_blk            = '0;
    abc_blk[511:480]   = 32'h61626380;
    abc_blk[63:0]      = 64'h18;
    abcd1_blk          = {16{32'h61626364}};
    abcd2_blk          = '0;
    abcd2_blk[511:480] = 32'h80000000;
    abcd2_blk[63:0]    = 64'h200;

    rst            = 1'b1;
    bus.req_valid  = 2'b11;
    bus.req_first  = 2'b00;
    bus.req_block0 = '0;
    bus.req_block1 = '0;
    cycle();
    cycle();
    #1;
    chk("rst_ready", 256'(bus.req_ready), 256'd0);
    chk("rst_enable", 256'(bus.cf_enable), 256'd0);
    chk("rst_inputV", bus.cf_inputV, 256'd0);
    chk("rst_block", bus.cf_messageBlock[255:0], 256'd0);
    chk("rst_resp_v", bus.resp_v, 256'd0);
    chk("rst_resp_valid", 256'(bus.resp_valid), 256'd0);
    chk("rst_wdog", 256'(wdog_err), 256'd0);
    bus.req_valid = 2'b00;
    rst           = 1'b0;
    mchain[0]     = IV;
    mchain[1]     = IV;
    cycle();

    for (int k = 0; k < 10; k++) begin
      blk_be[0] = rand512();
      blk_be[1] = rand512();
      core_lat  = $urandom_range(0, 4);
      issue(tbl[k].valid, tbl[k].first, tbl[k].grant, 1'b1, $sformatf("tbl%0d", k));
      drain($sformatf("tbl%0d", k));
    end

    // Single "abc" block with the response and re-grant timing pinned down.
    do_reset();
    blk_be[0] = abc_blk;
    blk_be[1] = rand512();
    core_lat  = 3;
    issue(2'b01, 2'b01, 2'b01, 1'b1, "abc");
    n = 0;
    while (!bus.cf_finished && n < 20) begin
      cycle();
      n++;
    end
    chk("abc_finished", 256'(bus.cf_finished), 256'd1);
    bus.req_block1 = rev512(blk_be[1]);
    bus.req_first  = 2'b10;
    bus.req_valid  = 2'b10;
    cycle();
    #1;
    chk("abc_digest", bus.resp_v, ABC_DIGEST);
    chk("release_enable", 256'(bus.cf_enable), 256'd0);
    chk("release_ready", 256'(bus.req_ready), 256'd0);
    cycle();
    #1;
    chk("regrant_F2", 256'(bus.req_ready), 256'd2);
    issue(2'b10, 2'b10, 2'b10, 1'b1, "abc_r1");
    drain("abc_r1");

    // Two-block message on requester 0 interleaved with "abc" on requester 1.
    do_reset();
    core_lat  = 2;
    blk_be[0] = abcd1_blk;
    blk_be[1] = abc_blk;
    issue(2'b11, 2'b11, 2'b01, 1'b1, "il_a");
    drain("il_a");
    blk_be[0] = abcd2_blk;
    issue(2'b11, 2'b10, 2'b10, 1'b1, "il_b");
    drain("il_b");
    chk("il_abc_digest", bus.resp_v, ABC_DIGEST);
    issue(2'b01, 2'b00, 2'b01, 1'b1, "il_c");
    drain("il_c");
    chk("il_abcd_digest", bus.resp_v, ABCD_DIGEST);

    // Hung core: watchdog fires, no response, chain untouched, next grant works.
    core_hang = 1'b1;
    blk_be[0] = rand512();
    issue(2'b01, 2'b00, 2'b01, 1'b0, "wd");
    n = 0;
    while (!wdog_err && n < WDOG + 10) begin
      cycle();
      n++;
    end
    chk("wdog_set", 256'(wdog_err), 256'd1);
    chk("wdog_delay", 256'(n >= WDOG && n <= WDOG + 1), 256'd1);
    #1;
    chk("wdog_release_en", 256'(bus.cf_enable), 256'd0);
    core_hang = 1'b0;
    blk_be[0] = rand512();
    issue(2'b01, 2'b00, 2'b01, 1'b1, "wd_next");
    drain("wd_next");
    chk("wdog_sticky", 256'(wdog_err), 256'd1);

    // Reset mid-block, then a stale finish from the core.
    core_hang = 1'b1;
    blk_be[1] = rand512();
    issue(2'b10, 2'b00, 2'b10, 1'b0, "rb");
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    #1;
    chk("rb_enable", 256'(bus.cf_enable), 256'd0);
    chk("rb_resp_valid", 256'(bus.resp_valid), 256'd0);
    chk("rb_wdog", 256'(wdog_err), 256'd0);
    chk("rb_resp_v", bus.resp_v, 256'd0);
    rst       = 1'b0;
    mchain[0] = IV;
    mchain[1] = IV;
    core_hang = 1'b0;
    fin_req++;
    cycle();
    cycle();
    cycle();
    #1;
    chk("stale_enable", 256'(bus.cf_enable), 256'd0);
    blk_be[0] = rand512();
    blk_be[1] = rand512();
    issue(2'b01, 2'b00, 2'b01, 1'b1, "post0");
    drain("post0");
    issue(2'b10, 2'b00, 2'b10, 1'b1, "post1");
    drain("post1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
